// File: rtl/motion_cmd_gen.sv
// Debounced, speed-ramped motion command source with a valid/ready output and a request watchdog.
// Direction changes always brake to zero first; silence on req_valid forces a controlled stop.
module motion_cmd_gen #(
   parameter int unsigned STABLE_COUNT   = 3,
   parameter int unsigned RAMP_TICKS     = 2_500_000,
   parameter int unsigned TIMEOUT_CYCLES = 25_000_000,
   parameter int unsigned MAX_SPEED      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req_cmd,
   input  logic       req_valid,
   input  logic [3:0] speed_target,
   output logic [3:0] move_cmd,
   output logic [3:0] speed_level,
   output logic       valid,
   input  logic       ready,
   output logic       timeout_stop
);

   typedef enum logic [1:0] {StIdle, StRun, StBrake} state_e;

   state_e      state;
   logic [3:0]  code, cand, cand_nxt, accepted, target;
   logic [31:0] cnt, cnt_nxt, wd_cnt, ramp_cnt;
   logic        tick_pend, step, idle_go;

   always_comb begin
      code     = (req_cmd <= 4'd4) ? req_cmd : 4'd0;
      target   = (speed_target > 4'(MAX_SPEED)) ? 4'(MAX_SPEED) : speed_target;
      cand_nxt = cand;
      cnt_nxt  = cnt;
      if (code == cand) begin
         if (cnt < STABLE_COUNT) cnt_nxt = cnt + 32'd1;
      end else begin
         cand_nxt = code;
         cnt_nxt  = 32'd1;
      end
   end

   // Debounce and watchdog; the watchdog saturates once it has fired.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cand         <= 4'd0;
         cnt          <= 32'd0;
         accepted     <= 4'd0;
         wd_cnt       <= 32'd0;
         timeout_stop <= 1'b0;
      end else if (req_valid) begin
         cand         <= cand_nxt;
         cnt          <= cnt_nxt;
         wd_cnt       <= 32'd0;
         timeout_stop <= 1'b0;
         if (cnt_nxt == STABLE_COUNT) accepted <= cand_nxt;
      end else if (wd_cnt < TIMEOUT_CYCLES) begin
         wd_cnt <= wd_cnt + 32'd1;
         if (wd_cnt == TIMEOUT_CYCLES - 1) begin
            timeout_stop <= 1'b1;
            accepted     <= 4'd0;
            cnt          <= 32'd0;
         end
      end
   end

   always_comb begin
      idle_go = (state == StIdle) && !valid && (accepted != 4'd0) && (target != 4'd0);
      step    = tick_pend && !valid &&
                ((state == StBrake) ||
                 ((state == StRun) && (accepted == move_cmd) && (target != speed_level)));
   end

   // Ramp timer restarts on every emitted transfer so consecutive steps are a full period apart.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= StIdle;
         move_cmd    <= 4'd0;
         speed_level <= 4'd0;
         valid       <= 1'b0;
         ramp_cnt    <= 32'd0;
         tick_pend   <= 1'b0;
      end else begin
         if (valid && ready) valid <= 1'b0;

         if (idle_go || step) begin
            ramp_cnt  <= 32'd0;
            tick_pend <= 1'b0;
         end else if (ramp_cnt == RAMP_TICKS - 1) begin
            ramp_cnt  <= 32'd0;
            tick_pend <= 1'b1;
         end else begin
            ramp_cnt <= ramp_cnt + 32'd1;
         end

         unique case (state)
            StIdle: begin
               if (idle_go) begin
                  move_cmd    <= accepted;
                  speed_level <= 4'd1;
                  valid       <= 1'b1;
                  state       <= StRun;
               end
            end
            StRun: begin
               if (accepted != move_cmd) begin
                  state <= StBrake;
               end else if (step) begin
                  valid <= 1'b1;
                  if (target > speed_level) begin
                     speed_level <= speed_level + 4'd1;
                  end else if (speed_level > 4'd1) begin
                     speed_level <= speed_level - 4'd1;
                  end else begin
                     move_cmd    <= 4'd0;
                     speed_level <= 4'd0;
                     state       <= StIdle;
                  end
               end
            end
            StBrake: begin
               if (step) begin
                  valid <= 1'b1;
                  if (speed_level > 4'd1) begin
                     speed_level <= speed_level - 4'd1;
                  end else begin
                     move_cmd    <= 4'd0;
                     speed_level <= 4'd0;
                     state       <= StIdle;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
